// File: rtl/pwm_pulse_decoder_if.sv
// Signal bundle between the PWM input pin and the duty-code consumer.
// The decoder takes the master modport; the consumer or driver takes the slave modport.
interface pwm_pulse_decoder_if;
  logic       pwm_in;
  logic [6:0] duty_cycle;
  logic       sample_valid;
  logic       range_err;
  logic       locked;
  logic       lost;

  modport master (
    input  pwm_in,
    output duty_cycle,
    output sample_valid,
    output range_err,
    output locked,
    output lost
  );

  modport slave (
    output pwm_in,
    input  duty_cycle,
    input  sample_valid,
    input  range_err,
    input  locked,
    input  lost
  );
endinterface

// File: rtl/pwm_pulse_decoder.sv
// Servo-style PWM receiver: measures pulse high time and recovers the duty code
// by round-to-nearest without a divider; flags out-of-range pulses and signal loss.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARM       | wait for a low input so a pulse already in flight is skipped
// WAIT_RISE | idle low, waiting for the next rising edge
// MEASURE   | input high, counting; evaluate the pulse on the falling edge
module pwm_pulse_decoder #(
  parameter int unsigned BASE_CYCLES    = 100000,
  parameter int unsigned STEP_CYCLES    = 1000,
  parameter int unsigned MAX_DUTY       = 99,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic                 clk,
  input  logic                 reset,
  pwm_pulse_decoder_if.master  pwm
);

  localparam int H_W   = 18;
  localparam int PS_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PER_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [H_W-1:0]   H_MAX    = {H_W{1'b1}};
  localparam logic [H_W-1:0]   THRESH_H = H_W'(BASE_CYCLES - STEP_CYCLES / 2);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(STEP_CYCLES - 1);
  localparam logic [6:0]       U_SAT    = 7'(MAX_DUTY + 1);
  localparam logic [6:0]       DUTY_MAX = 7'(MAX_DUTY);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_ARM       = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_MEASURE   = 2'd2;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [1:0]       state_q, state_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [6:0]       u_q, u_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [6:0]       duty_q, duty_d;
  logic             sample_valid_q, sample_valid_d;
  logic             range_err_q, range_err_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;

  logic             rise;
  logic             fall;
  logic             timeout;
  logic [H_W-1:0]   h_base, h_inc;
  logic [PS_W-1:0]  ps_base, ps_inc;
  logic [6:0]       u_base, u_inc;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // A rise also counts as the first high cycle, so h ends equal to the pin high width.
  always_comb begin
    h_base  = rise ? '0 : h_q;
    ps_base = rise ? '0 : ps_q;
    u_base  = rise ? '0 : u_q;
    h_inc   = h_base;
    ps_inc  = ps_base;
    u_inc   = u_base;
    if (h_base != H_MAX) begin
      h_inc = h_base + 1'b1;
      if (h_inc > THRESH_H) begin
        if (ps_base == PS_LAST) begin
          ps_inc = '0;
          if (u_base != U_SAT) begin
            u_inc = u_base + 1'b1;
          end
        end else begin
          ps_inc = ps_base + 1'b1;
        end
      end
    end
  end

  assign timeout = (state_q != ST_ARM) && !rise && (per_q == PER_LAST);

  always_comb begin
    s1_d           = pwm.pwm_in;
    s2_d           = s1_q;
    s3_d           = s2_q;
    state_d        = state_q;
    h_d            = h_q;
    ps_d           = ps_q;
    u_d            = u_q;
    duty_d         = duty_q;
    sample_valid_d = 1'b0;
    range_err_d    = 1'b0;
    locked_d       = locked_q;
    lost_d         = lost_q;

    if (state_q == ST_ARM || rise) begin
      per_d = '0;
    end else begin
      per_d = per_q + 1'b1;
    end

    case (state_q)
      ST_ARM: begin
        if (!s2_q) begin
          state_d = ST_WAIT_RISE;
        end
      end
      ST_WAIT_RISE: begin
        if (rise) begin
          h_d     = h_inc;
          ps_d    = ps_inc;
          u_d     = u_inc;
          lost_d  = 1'b0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (fall) begin
          state_d = ST_WAIT_RISE;
          if (h_q < THRESH_H) begin
            range_err_d = 1'b1;
          end else if (u_q > DUTY_MAX) begin
            duty_d         = DUTY_MAX;
            sample_valid_d = 1'b1;
            range_err_d    = 1'b1;
            locked_d       = 1'b1;
          end else begin
            duty_d         = u_q;
            sample_valid_d = 1'b1;
            locked_d       = 1'b1;
          end
        end else begin
          h_d  = h_inc;
          ps_d = ps_inc;
          u_d  = u_inc;
        end
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase

    // Timeout beats a coincident fall: the pulse is dropped without strobes.
    if (timeout) begin
      state_d        = ST_ARM;
      per_d          = '0;
      duty_d         = duty_q;
      sample_valid_d = 1'b0;
      range_err_d    = 1'b0;
      locked_d       = 1'b0;
      lost_d         = 1'b1;
    end
  end

  // Synchronizer resets high so a pin that is high out of reset reads as mid-pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q           <= 1'b1;
      s2_q           <= 1'b1;
      s3_q           <= 1'b1;
      state_q        <= ST_ARM;
      h_q            <= '0;
      ps_q           <= '0;
      u_q            <= '0;
      per_q          <= '0;
      duty_q         <= '0;
      sample_valid_q <= 1'b0;
      range_err_q    <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      state_q        <= state_d;
      h_q            <= h_d;
      ps_q           <= ps_d;
      u_q            <= u_d;
      per_q          <= per_d;
      duty_q         <= duty_d;
      sample_valid_q <= sample_valid_d;
      range_err_q    <= range_err_d;
      locked_q       <= locked_d;
      lost_q         <= lost_d;
    end
  end

  assign pwm.duty_cycle   = duty_q;
  assign pwm.sample_valid = sample_valid_q;
  assign pwm.range_err    = range_err_q;
  assign pwm.locked       = locked_q;
  assign pwm.lost         = lost_q;

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// Scoreboard bench for pwm_pulse_decoder with scaled timing parameters.
// Each driven pulse pushes its expected strobe; a negedge monitor pops and compares.
module tb_pwm_pulse_decoder;
  localparam int B    = 100;
  localparam int S    = 10;
  localparam int MAXD = 99;
  localparam int TO   = 4000;

  typedef struct {
    int duty;
    int valid;
    int err;
    int at;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_duty = 0;
  int   rise_cyc = 0;
  exp_t sb[$];
  exp_t e;

  pwm_pulse_decoder_if ifc ();

  pwm_pulse_decoder #(
    .BASE_CYCLES(B),
    .STEP_CYCLES(S),
    .MAX_DUTY(MAXD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pwm(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: round-to-nearest by division, ties up, clamp above MAXD.
  task automatic model(input int h, input int fall_cyc);
    exp_t x;
    int   u;
    x.at = fall_cyc + 3;
    if (h < B - S / 2) begin
      x.duty = last_duty; x.valid = 0; x.err = 1;
    end else begin
      u = (h - (B - S / 2)) / S;
      if (u > MAXD) begin
        last_duty = MAXD; x.duty = MAXD; x.valid = 1; x.err = 1;
      end else begin
        last_duty = u; x.duty = u; x.valid = 1; x.err = 0;
      end
    end
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!reset && (ifc.sample_valid || ifc.range_err)) begin
      if (sb.size() == 0) begin
        chk("stray_strobe", int'({ifc.sample_valid, ifc.range_err}), 0);
      end else begin
        e = sb.pop_front();
        chk("strobe_cycle", cyc, e.at);
        chk("sample_valid", int'(ifc.sample_valid), e.valid);
        chk("range_err", int'(ifc.range_err), e.err);
        chk("duty_cycle", int'(ifc.duty_cycle), e.duty);
      end
    end
  end

  task automatic rise_pin();
    @(posedge clk); #1;
    ifc.pwm_in = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic fall_after(input int hi, input bit expect_strobe);
    while (cyc < rise_cyc + hi) begin
      @(posedge clk); #1;
    end
    ifc.pwm_in = 1'b0;
    if (expect_strobe) model(hi, cyc);
  endtask

  task automatic low_for(input int lo);
    repeat (lo) @(posedge clk);
    #1;
    chk("strobe_missed", sb.size(), 0);
  endtask

  task automatic pulse(input int hi, input int lo);
    rise_pin();
    fall_after(hi, 1'b1);
    low_for(lo);
  endtask

  task automatic wait_lost();
    @(negedge clk);
    while (!ifc.lost && (cyc - rise_cyc) < TO + 100) @(negedge clk);
    chk("lost_set", int'(ifc.lost), 1);
    chk("lost_latency", cyc - rise_cyc, TO + 3);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_duty"}, int'(ifc.duty_cycle), 0);
    chk({tag, "_valid"}, int'(ifc.sample_valid), 0);
    chk({tag, "_err"}, int'(ifc.range_err), 0);
    chk({tag, "_locked"}, int'(ifc.locked), 0);
    chk({tag, "_lost"}, int'(ifc.lost), 0);
  endtask

  initial begin
    ifc.pwm_in = 1'b0;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    pulse(100, 1500);
    chk("locked_after_first", int'(ifc.locked), 1);
    chk("lost_after_first", int'(ifc.lost), 0);
    pulse(600, 1500);
    pulse(1090, 1500);
    pulse(604, 1500);
    pulse(605, 1500);
    pulse(95, 1500);
    pulse(94, 1500);
    pulse(600, 1500);
    pulse(40, 1500);
    chk("locked_after_reject", int'(ifc.locked), 1);
    pulse(1600, 1500);
    pulse(1095, 1500);
    pulse(1094, 1500);

    // Loss with pin held low.
    wait_lost();
    chk("locked_after_loss", int'(ifc.locked), 0);
    chk("duty_held_on_loss", int'(ifc.duty_cycle), last_duty);
    rise_pin();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lost_before_rise_seen", int'(ifc.lost), 1);
    @(negedge clk);
    chk("lost_cleared_at_rise", int'(ifc.lost), 0);
    fall_after(300, 1'b1);
    low_for(1500);
    chk("relocked", int'(ifc.locked), 1);

    // Loss with pin stuck high; the late fall must be ignored.
    rise_pin();
    wait_lost();
    chk("locked_after_stuck", int'(ifc.locked), 0);
    fall_after(TO + 50, 1'b0);
    low_for(1500);
    pulse(200, 1500);
    chk("lost_after_recover", int'(ifc.lost), 0);

    // Reset in the middle of a pulse.
    rise_pin();
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    last_duty = 0;
    @(negedge clk);
    check_idle_outputs("post_reset");
    fall_after(300, 1'b0);
    low_for(1500);
    pulse(400, 1500);
    chk("final_duty", int'(ifc.duty_cycle), 30);
    chk("final_locked", int'(ifc.locked), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
